prediction_history_ctrl: RTL and testbench

Sits directly upstream of the two-digit 7-segment display controller and produces its digit_left/digit_right inputs. Captures each classifier result into a circular history buffer. Drives the newest result on the right digit and the one before it on the left digit. Two debounced push-buttons let the user scroll back through older results.

---
 rtl/prediction_history_ctrl.sv | 168 ++++++++++++++++
 tb/tb_prediction_history_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/prediction_history_ctrl.sv
// Prediction history buffer feeding the two-digit display: newest result on the right,
// the one before it on the left, with debounced buttons to scroll back through history.
module prediction_history_ctrl #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic [3:0]  BLANK_CODE      = 4'hF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [3:0]               pred_class,
    input  logic                     btn_prev,
    input  logic                     btn_next,
    input  logic                     clear,
    output logic [3:0]               digit_left,
    output logic [3:0]               digit_right,
    output logic [$clog2(DEPTH):0]   history_count,
    output logic [$clog2(DEPTH)-1:0] view_offset,
    output logic                     at_live
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

    localparam logic [PW-1:0] PtrOne   = PW'(1);
    localparam logic [CW-1:0] CntOne   = CW'(1);
    localparam logic [CW-1:0] CountMax = CW'(DEPTH);
    localparam logic [DW-1:0] DbOne    = DW'(1);
    localparam logic [DW-1:0] DbMax    = DW'(DEBOUNCE_CYCLES - 1);

    // Button path; index 0 = prev, index 1 = next
    logic [1:0]    btn_raw;
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    level_q, level_d;
    logic [1:0]    press_q, press_d;
    logic [DW-1:0] db_cnt_q [2];
    logic [DW-1:0] db_cnt_d [2];

    assign btn_raw = {btn_next, btn_prev};

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = db_cnt_q[i];
            press_d[i]  = 1'b0;
            if (sync2_q[i] == level_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DbMax) begin
                level_d[i]  = sync2_q[i];
                db_cnt_d[i] = '0;
                press_d[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DbOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < 2; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    // History buffer and view state
    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] view_q, view_d;
    logic [3:0]    digit_left_q, digit_left_d;
    logic [3:0]    digit_right_q, digit_right_d;
    logic          at_live_q, at_live_d;
    logic          wr_en;
    logic          prev_pulse, next_pulse;
    logic [CW-1:0] age_r, age_l;
    logic [PW-1:0] idx_r, idx_l;

    assign wr_en      = pred_valid & ~clear;
    assign prev_pulse = press_q[0] & ~press_q[1];
    assign next_pulse = press_q[1] & ~press_q[0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        view_d   = view_q;
        if (clear) begin
            wr_ptr_d = '0;
            count_d  = '0;
            view_d   = '0;
        end else if (pred_valid) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            count_d  = (count_q == CountMax) ? count_q : count_q + CntOne;
            view_d   = '0;
        end else if (prev_pulse) begin
            if (({1'b0, view_q} + CntOne) < count_q) begin
                view_d = view_q + PtrOne;
            end
        end else if (next_pulse) begin
            if (view_q != '0) begin
                view_d = view_q - PtrOne;
            end
        end
    end

    // Outputs are built from post-update state; the slot written this cycle is bypassed
    always_comb begin
        age_r = {1'b0, view_d};
        age_l = age_r + CntOne;
        idx_r = wr_ptr_d - PtrOne - age_r[PW-1:0];
        idx_l = wr_ptr_d - PtrOne - age_l[PW-1:0];

        digit_right_d = BLANK_CODE;
        if (age_r < count_d) begin
            digit_right_d = (wr_en && idx_r == wr_ptr_q) ? pred_class : mem_q[idx_r];
        end
        digit_left_d = BLANK_CODE;
        if (age_l < count_d) begin
            digit_left_d = (wr_en && idx_l == wr_ptr_q) ? pred_class : mem_q[idx_l];
        end
        at_live_d = (view_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            count_q       <= '0;
            view_q        <= '0;
            digit_left_q  <= BLANK_CODE;
            digit_right_q <= BLANK_CODE;
            at_live_q     <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            view_q        <= view_d;
            digit_left_q  <= digit_left_d;
            digit_right_q <= digit_right_d;
            at_live_q     <= at_live_d;
        end
    end

    // Contents need no reset: unwritten slots are masked by count_q
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem_q[wr_ptr_q] <= pred_class;
        end
    end

    assign digit_left    = digit_left_q;
    assign digit_right   = digit_right_q;
    assign history_count = count_q;
    assign view_offset   = view_q;
    assign at_live       = at_live_q;

endmodule

// File: tb/tb_prediction_history_ctrl.sv
// Scoreboard bench for prediction_history_ctrl with DEPTH=8 and a 4-cycle debounce.
module tb_prediction_history_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid;
    logic [3:0] pred_class;
    logic       btn_prev;
    logic       btn_next;
    logic       clear;
    logic [3:0] digit_left;
    logic [3:0] digit_right;
    logic [3:0] history_count;
    logic [2:0] view_offset;
    logic       at_live;

    prediction_history_ctrl #(
        .DEPTH           (8),
        .DEBOUNCE_CYCLES (4),
        .BLANK_CODE      (4'hF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pred_valid    (pred_valid),
        .pred_class    (pred_class),
        .btn_prev      (btn_prev),
        .btn_next      (btn_next),
        .clear         (clear),
        .digit_left    (digit_left),
        .digit_right   (digit_right),
        .history_count (history_count),
        .view_offset   (view_offset),
        .at_live       (at_live)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] left;
        logic [3:0] right;
        logic [3:0] count;
        logic [2:0] view;
        logic       live;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];
    logic  chk_req = 1'b0;
    int    checks   = 0;
    int    failures = 0;

    task automatic cmp(input string nm, input string field, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    // Monitor: pops the expected snapshot whenever the stimulus flags a settled state
    always @(negedge clk) begin
        if (chk_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow actual=0 required=1");
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "left",  int'(digit_left),    int'(e.left));
                cmp(nm, "right", int'(digit_right),   int'(e.right));
                cmp(nm, "count", int'(history_count), int'(e.count));
                cmp(nm, "view",  int'(view_offset),   int'(e.view));
                cmp(nm, "live",  int'(at_live),       int'(e.live));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_st(input string nm, input logic [3:0] l, input logic [3:0] r,
                             input logic [3:0] c, input logic [2:0] v, input logic live);
        exp_t e;
        e.left  = l;
        e.right = r;
        e.count = c;
        e.view  = v;
        e.live  = live;
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_req = 1'b1;
        tick(1);
        chk_req = 1'b0;
    endtask

    task automatic pred(input logic [3:0] c);
        pred_valid = 1'b1;
        pred_class = c;
        tick(1);
        pred_valid = 1'b0;
    endtask

    task automatic press_prev();
        btn_prev = 1'b1;
        tick(12);
        btn_prev = 1'b0;
        tick(12);
    endtask

    task automatic press_next();
        btn_next = 1'b1;
        tick(12);
        btn_next = 1'b0;
        tick(12);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        pred_valid = 1'b0;
        pred_class = 4'h0;
        btn_prev   = 1'b0;
        btn_next   = 1'b0;
        clear      = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(10);
        expect_st("reset", 4'hF, 4'hF, 4'd0, 3'd0, 1'b1);

        pred(4'd3);
        expect_st("pred3", 4'hF, 4'd3, 4'd1, 3'd0, 1'b1);
        pred(4'd7);
        expect_st("pred7", 4'd3, 4'd7, 4'd2, 3'd0, 1'b1);

        for (int i = 0; i < 10; i++) begin
            pred(4'(i));
        end
        expect_st("full", 4'd8, 4'd9, 4'd8, 3'd0, 1'b1);

        // Newest-first ages hold 9,8,...,2
        for (int k = 1; k <= 7; k++) begin
            press_prev();
            expect_st($sformatf("prev%0d", k), (k == 7) ? 4'hF : 4'(8 - k), 4'(9 - k),
                      4'd8, 3'(k), 1'b0);
        end
        press_prev();
        expect_st("prev_sat", 4'hF, 4'd2, 4'd8, 3'd7, 1'b0);

        for (int k = 0; k < 4; k++) begin
            press_next();
        end
        expect_st("next4", 4'd5, 4'd6, 4'd8, 3'd3, 1'b0);

        for (int k = 0; k < 4; k++) begin
            btn_prev = 1'b1;
            tick(3);
            btn_prev = 1'b0;
            tick(3);
        end
        tick(10);
        expect_st("bounce", 4'd5, 4'd6, 4'd8, 3'd3, 1'b0);

        btn_prev = 1'b1;
        tick(10);
        btn_prev = 1'b0;
        tick(12);
        expect_st("stable", 4'd4, 4'd5, 4'd8, 3'd4, 1'b0);

        press_next();
        expect_st("next_back", 4'd5, 4'd6, 4'd8, 3'd3, 1'b0);

        // Line pred_valid up with the debounced next pulse
        btn_next = 1'b1;
        tick(6);
        pred_valid = 1'b1;
        pred_class = 4'd5;
        tick(1);
        pred_valid = 1'b0;
        expect_st("pred_vs_next", 4'd9, 4'd5, 4'd8, 3'd0, 1'b1);
        btn_next = 1'b0;
        tick(12);
        expect_st("after_snap", 4'd9, 4'd5, 4'd8, 3'd0, 1'b1);

        clear      = 1'b1;
        pred_valid = 1'b1;
        pred_class = 4'd4;
        tick(1);
        clear      = 1'b0;
        pred_valid = 1'b0;
        expect_st("clear_vs_pred", 4'hF, 4'hF, 4'd0, 3'd0, 1'b1);
        pred(4'd6);
        expect_st("post_clear", 4'hF, 4'd6, 4'd1, 3'd0, 1'b1);

        pred(4'd1);
        pred(4'd2);
        btn_prev = 1'b1;
        tick(4);
        rst      = 1'b1;
        btn_prev = 1'b0;
        tick(2);
        rst = 1'b0;
        pred(4'd1);
        pred(4'd2);
        tick(12);
        expect_st("rst_mid_db", 4'd1, 4'd2, 4'd2, 3'd0, 1'b1);

        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
